// File: rtl/pla_minterm_scanner.sv
// pla_minterm_scanner
// Drives an N_IN-input single-output function through every input assignment
// in ascending order. Each ON-set minterm is streamed out over a valid/ready
// channel, and the ON-set minterms are counted.
module pla_minterm_scanner #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] fn_x,
  input  logic            fn_y,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [N_IN-1:0] m_data,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   onset_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N_IN-1:0] IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]   CNT_ONE = {{N_IN{1'b0}}, 1'b1};

  logic [1:0]      state_reg, state_next;
  logic [N_IN-1:0] idx_reg, idx_next;
  logic            valid_reg, valid_next;
  logic [N_IN-1:0] data_reg, data_next;
  logic [N_IN:0]   count_reg, count_next;
  logic            idx_last;

  // The last minterm is all-ones; the index stops there and never wraps.
  assign idx_last = &idx_reg;

  // Next-state logic: abort beats everything while a scan is active.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    data_next  = data_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          idx_next   = '0;
          count_next = '0;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          valid_next = 1'b0;
          state_next = S_IDLE;
        end else if (fn_y) begin
          // The function output settled during this cycle, so the minterm is captured now.
          data_next  = idx_reg;
          valid_next = 1'b1;
          count_next = count_reg + CNT_ONE;
          state_next = S_HOLD;
        end else if (idx_last) begin
          state_next = S_DONE;
        end else begin
          idx_next = idx_reg + IDX_ONE;
        end
      end
      S_HOLD: begin
        if (abort) begin
          valid_next = 1'b0;
          state_next = S_IDLE;
        end else if (valid_reg && m_ready) begin
          valid_next = 1'b0;
          if (idx_last) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            state_next = S_SCAN;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        valid_next = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      count_reg <= count_next;
    end
  end

  // Outputs decode directly from state so that a reset forces them low at once.
  assign busy        = (state_reg == S_SCAN) || (state_reg == S_HOLD);
  assign done        = (state_reg == S_DONE);
  assign fn_x        = busy ? idx_reg : '0;
  assign m_valid     = valid_reg;
  assign m_data      = data_reg;
  assign onset_count = count_reg;

endmodule

// File: tb/tb_pla_minterm_scanner.sv
// Testbench for pla_minterm_scanner: the function under test is a truth table
// indexed by fn_x. Expected beats, counts and completion cycles come from the
// ON-set of that table.
module tb_pla_minterm_scanner;

  localparam int N = 8;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [N-1:0] fn_x;
  logic         fn_y;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic         busy;
  logic         done;
  logic [N:0]   onset_count;

  bit truth [0:M-1];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int kind;
    int exp_count;
    int exp_done;
    bit chk_seq;
  } vec_t;

  vec_t vecs [0:4];

  always #5 clk = ~clk;

  assign fn_y = truth[fn_x];

  pla_minterm_scanner #(.N_IN(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .fn_x        (fn_x),
    .fn_y        (fn_y),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .done        (done),
    .onset_count (onset_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < M; i++) if (truth[i]) c++;
    return c;
  endfunction

  task automatic set_truth(input int kind);
    for (int i = 0; i < M; i++) begin
      case (kind)
        0: truth[i] = 1'b0;
        1: truth[i] = (i == 'hA5);
        2: truth[i] = 1'b1;
        3: truth[i] = (i % 2) == 1;
        default: truth[i] = (i == 0) || (i == M - 1);
      endcase
    end
  endtask

  // Runs one full scan from the current cycle. ready_mode: 0 always ready,
  // 1 random ready, 2 stall the first beat for 5 cycles. Beats are compared
  // in order against the ascending ON-set list of the truth table.
  task automatic run_scan(input int ready_mode, input bit chk_seq, input int restart_at,
                          output int done_cyc, output int stalls);
    int exp_q[$];
    int cyc;
    int beats;
    int hold_cnt;
    bit prev_wait;
    logic [N-1:0] prev_data;
    logic [N-1:0] prev_x;
    for (int i = 0; i < M; i++) if (truth[i]) exp_q.push_back(i);
    start = 1'b1;
    cyc = 0; beats = 0; hold_cnt = 0; stalls = 0; done_cyc = -1;
    prev_wait = 1'b0; prev_data = '0; prev_x = '0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (beats == 0 && m_valid && hold_cnt < 5) begin
            m_ready = 1'b0;
            hold_cnt++;
          end else begin
            m_ready = 1'b1;
          end
        end
      endcase
      if (cyc == 1) begin
        check("busy_cycle1", busy, 1);
        check("fn_x_cycle1", fn_x, 0);
      end
      if (chk_seq && cyc <= M) check("fn_x_step", fn_x, cyc - 1);
      if (prev_wait) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_fn_x", fn_x, prev_x);
      end
      if (m_valid && !m_ready) stalls++;
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got m_data=0x%02h, expected no more beats", m_data);
        end else begin
          check("beat_data", m_data, exp_q.pop_front());
        end
        $display("beat %0d m_data=0x%02h onset_count=%0d", beats, m_data, onset_count);
      end
      prev_wait = m_valid && !m_ready;
      prev_data = m_data;
      prev_x    = fn_x;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout: got no done within 3000 cycles, expected done");
    end
    check("busy_at_done", busy, 0);
    check("missing_beats", exp_q.size(), 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_fn_x", fn_x, 0);
  endtask

  initial begin
    int dc;
    int st;
    int k;

    vecs[0] = '{kind: 0, exp_count: 0,   exp_done: 257, chk_seq: 1'b1};
    vecs[1] = '{kind: 1, exp_count: 1,   exp_done: 258, chk_seq: 1'b0};
    vecs[2] = '{kind: 2, exp_count: 256, exp_done: 513, chk_seq: 1'b0};
    vecs[3] = '{kind: 3, exp_count: 128, exp_done: 385, chk_seq: 1'b0};
    vecs[4] = '{kind: 4, exp_count: 2,   exp_done: 259, chk_seq: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
    set_truth(0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_fn_x", fn_x, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", onset_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven full scans with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      set_truth(vecs[v].kind);
      run_scan(0, vecs[v].chk_seq, -1, dc, st);
      $display("scan kind=%0d done_cycle=%0d onset_count=%0d", vecs[v].kind, dc, onset_count);
      check("table_count", onset_count, vecs[v].exp_count);
      check("model_count", onset_count, popcount());
      check("table_done_cycle", dc, vecs[v].exp_done);
    end

    // First beat stalled for 5 cycles on fn_y = fn_x[0].
    set_truth(3);
    run_scan(2, 1'b0, -1, dc, st);
    $display("stall scan done_cycle=%0d stalls=%0d", dc, st);
    check("stall_cycles", st, 5);
    check("stall_count", onset_count, 128);
    check("stall_done_cycle", dc, M + 128 + 1 + 5);

    // A start pulse in the middle of a scan must not restart it.
    run_scan(0, 1'b0, 50, dc, st);
    $display("restart-ignored scan done_cycle=%0d", dc);
    check("busy_start_done_cycle", dc, 385);
    check("busy_start_count", onset_count, 128);

    // Abort while holding minterm 0x41.
    m_ready = 1'b1;
    start = 1'b1;
    k = 0;
    while (k < 1000) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (m_valid && m_data == 8'h41) begin
        m_ready = 1'b0;
        abort = 1'b1;
        break;
      end
      m_ready = 1'b1;
    end
    check("abort_reached_0x41", m_data, 8'h41);
    check("abort_count_before", onset_count, 33);
    @(posedge clk); #1;
    abort = 1'b0;
    m_ready = 1'b1;
    $display("abort at 0x41 onset_count=%0d", onset_count);
    check("abort_m_valid", m_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_count_kept", onset_count, 33);
    check("abort_fn_x", fn_x, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", done, 0);
      @(posedge clk); #1;
    end

    // Restart after abort begins again from minterm 0 with a cleared count.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_fn_x", fn_x, 0);
    check("restart_count", onset_count, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("restart_abort_busy", busy, 0);

    // Randomized truth tables with a randomly stalling consumer.
    for (int r = 0; r < 4; r++) begin
      int dens;
      dens = $urandom_range(0, 100);
      for (int i = 0; i < M; i++) truth[i] = ($urandom_range(0, 99) < dens);
      k = popcount();
      run_scan(1, 1'b0, -1, dc, st);
      $display("random scan %0d K=%0d stalls=%0d done_cycle=%0d", r, k, st, dc);
      check("rand_count", onset_count, k);
      check("rand_done_cycle", dc, M + k + 1 + st);
    end

    // Asynchronous reset in the middle of a scan.
    set_truth(2);
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_fn_x", fn_x, 0);
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_m_data", m_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_count", onset_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
